sys1_input_ctrl: RTL and testbench
==================================

SYS1_INPUT_CTRL -- requirements
Module: sys1_input_ctrl

Interface
REQ-001 Parameter COIN_FRAMES, default 3, coin-active length in vblank rising edges (legal 1..15).
REQ-002 Parameter GAP_FRAMES, default 3, minimum coin-inactive length in vblank rising edges before re-arm (legal 1..15).
REQ-003 clk_sys  in  1  single system clock; every register is rising-edge clk_sys.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 ps2_key  in  11  keyboard event bus:
- [10] toggles once per event.
- [9] pressed.
- [8] extended.
- [7:0] scan code.
REQ-006 joy1, joy2  in  16 each  active-high pads:
- [0] right, [1] left, [2] down, [3] up.
- [4] trig1, [5] trig2.
- [6] start1, [7] start2, [8] coin.
REQ-007 cabinet  in  1  1 = cocktail (P2 separate); 0 = upright (P2 controls also drive P1).
REQ-008 vblank  in  1  video vertical blank, synchronous to clk_sys.
REQ-009 inp0, inp1  out  8 each  active-low P1/P2 ports, bit order {left,right,up,down,0,trig2,trig1,0}.
REQ-010 inp2  out  8  active-low system port, bit order {0,0,start2,start1,0,0,0,coin}.
REQ-011 coin_busy  out  1  high while the coin FSM is not IDLE.

Function
REQ-012 A key event shall be detected when ps2_key[10] differs from the registered copy of its previous value; the copy updates every cycle.
REQ-013 On an event, the matching key latch shall load ps2_key[9]; codes match on {ps2_key[8],ps2_key[7:0]}.
REQ-014 Extended-agnostic key map:
- 75 up; 72 down; 6B left; 74 right.
REQ-015 Non-extended key map:
- P1 / system: 29 trig1; 14 trig2; 05 F1; 06 F2; 16 start1; 1E start2; 2E coin1; 36 coin2.
- P2: 2D up2; 2B down2; 23 left2; 34 right2; 1C trig1_2; 1B trig2_2.
- Unmapped codes change nothing.
REQ-016 P2 signals: key latch OR joy2 bit.
REQ-017 P1 signals: key latch OR joy1 bit, OR the P2 signal when cabinet=0.
REQ-018 start1 = F1|start1 key|joy1[6]|joy2[6]; start2 = F2|start2 key|joy1[7]|joy2[7].
REQ-019 Raw coin request = F1|F2|coin1|coin2|joy1[8]|joy2[8].
REQ-020 inp0/inp1/inp2 shall be registered.
- Latency: joy/cabinet change visible 1 cycle later; ps2 toggle change visible 2 cycles later.
REQ-021 Coin FSM states and transitions:
- IDLE -> PULSE on raw coin rising edge (registered previous value).
- PULSE -> GAP after COIN_FRAMES vblank rising edges.
- GAP -> REARM after GAP_FRAMES vblank rising edges.
- REARM -> IDLE when raw coin = 0.
REQ-022 inp2[0] shall be 0 exactly while in PULSE (registered from state), else 1.
REQ-023 Coin edges in PULSE, GAP or REARM shall be ignored (no queuing).
- A held coin yields one pulse only.
REQ-024 Frame counter: 4 bits; clears on every state entry; increments on a vblank rising edge; the transition fires on the edge where count+1 equals the target.
REQ-025 A vblank edge on the IDLE->PULSE cycle shall not count.
REQ-026 Simultaneous key event and joystick change in one cycle: both shall be reflected, the OR applied after the latch update.

Reset
REQ-027 While reset_n=0 at a clock edge:
- key latches -> 0; FSM -> IDLE; counter -> 0.
- inp0=inp1=inp2=8'hFF; coin_busy=0.
- toggle copy loads ps2_key[10]; previous-coin register loads the raw coin request.
REQ-028 Reset during PULSE shall end the coin pulse on the next cycle; no pulse is re-issued for a coin still held at reset release.

Verification
REQ-029 Reset, then ps2_key toggled with {pressed=1,ext=1,code=75} -> inp0=8'hDF two cycles later; toggle with pressed=0 -> inp0=8'hFF.
REQ-030 cabinet=0, joy2[4]=1 -> inp0=8'hFD and inp1=8'hFD; set cabinet=1 -> inp0=8'hFF next cycle, inp1 unchanged.
REQ-031 joy1[8] pulse for 1 cycle, defaults -> inp2[0]=0 for exactly 3 vblank rising edges, then 1; coin_busy stays 1 through 3 more edges, then drops.
REQ-032 Coin held high for 20 frames -> exactly one coin pulse; FSM stays in REARM until release, then IDLE.
REQ-033 Second coin edge during GAP -> ignored, no second pulse; a new edge after IDLE -> new pulse.
REQ-034 reset_n low for 1 cycle mid-PULSE with coin held -> inp2=8'hFF after reset; no pulse until coin released and pressed again.

Source files
------------

// File: rtl/sys1_input_ctrl.sv
// Keyboard/joystick to active-low cabinet ports, with a frame-timed coin pulse FSM.
// Joystick changes reach the ports in 1 cycle, keyboard events in 2; no backpressure.
module sys1_input_ctrl #(
  parameter int COIN_FRAMES = 3,
  parameter int GAP_FRAMES  = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic        cabinet,
  input  logic        vblank,
  output logic [7:0]  inp0,
  output logic [7:0]  inp1,
  output logic [7:0]  inp2,
  output logic        coin_busy
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, REARM} state_t;

  localparam logic [3:0] COIN_TGT = 4'(COIN_FRAMES);
  localparam logic [3:0] GAP_TGT  = 4'(GAP_FRAMES);

  state_t     state;
  logic [3:0] cnt;
  logic       coin_n;
  logic [6:0] sys_q;
  logic       toggle_q, vblank_q, raw_q;

  logic k_up, k_down, k_left, k_right, k_trig1, k_trig2;
  logic k_f1, k_f2, k_start1, k_start2, k_coin1, k_coin2;
  logic k_up2, k_down2, k_left2, k_right2, k_trig1_2, k_trig2_2;

  logic key_evt, vb_rise, coin_rise, raw_coin;
  logic up2, down2, left2, right2, trig1_2, trig2_2;
  logic up1, down1, left1, right1, trig1_1, trig2_1;
  logic start1, start2;
  logic unused_ok;

  assign key_evt   = ps2_key[10] ^ toggle_q;
  assign vb_rise   = vblank & ~vblank_q;
  assign coin_rise = raw_coin & ~raw_q;

  assign up2     = k_up2     | joy2[3];
  assign down2   = k_down2   | joy2[2];
  assign left2   = k_left2   | joy2[1];
  assign right2  = k_right2  | joy2[0];
  assign trig1_2 = k_trig1_2 | joy2[4];
  assign trig2_2 = k_trig2_2 | joy2[5];

  // Upright cabinets share one control panel, so P2 inputs also drive P1.
  assign up1     = k_up    | joy1[3] | (~cabinet & up2);
  assign down1   = k_down  | joy1[2] | (~cabinet & down2);
  assign left1   = k_left  | joy1[1] | (~cabinet & left2);
  assign right1  = k_right | joy1[0] | (~cabinet & right2);
  assign trig1_1 = k_trig1 | joy1[4] | (~cabinet & trig1_2);
  assign trig2_1 = k_trig2 | joy1[5] | (~cabinet & trig2_2);

  assign start1   = k_f1 | k_start1 | joy1[6] | joy2[6];
  assign start2   = k_f2 | k_start2 | joy1[7] | joy2[7];
  assign raw_coin = k_f1 | k_f2 | k_coin1 | k_coin2 | joy1[8] | joy2[8];

  assign unused_ok = ^{joy1[15:9], joy2[15:9]};

  // Edge-detect history keeps tracking through reset so release creates no false edges.
  always_ff @(posedge clk_sys) begin
    toggle_q <= ps2_key[10];
    vblank_q <= vblank;
    raw_q    <= raw_coin;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      {k_up, k_down, k_left, k_right, k_trig1, k_trig2}         <= '0;
      {k_f1, k_f2, k_start1, k_start2, k_coin1, k_coin2}        <= '0;
      {k_up2, k_down2, k_left2, k_right2, k_trig1_2, k_trig2_2} <= '0;
    end else if (key_evt) begin
      case ({ps2_key[8], ps2_key[7:0]})
        9'h075, 9'h175: k_up    <= ps2_key[9];
        9'h072, 9'h172: k_down  <= ps2_key[9];
        9'h06B, 9'h16B: k_left  <= ps2_key[9];
        9'h074, 9'h174: k_right <= ps2_key[9];
        9'h029: k_trig1   <= ps2_key[9];
        9'h014: k_trig2   <= ps2_key[9];
        9'h005: k_f1      <= ps2_key[9];
        9'h006: k_f2      <= ps2_key[9];
        9'h016: k_start1  <= ps2_key[9];
        9'h01E: k_start2  <= ps2_key[9];
        9'h02E: k_coin1   <= ps2_key[9];
        9'h036: k_coin2   <= ps2_key[9];
        9'h02D: k_up2     <= ps2_key[9];
        9'h02B: k_down2   <= ps2_key[9];
        9'h023: k_left2   <= ps2_key[9];
        9'h034: k_right2  <= ps2_key[9];
        9'h01C: k_trig1_2 <= ps2_key[9];
        9'h01B: k_trig2_2 <= ps2_key[9];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      inp0  <= 8'hFF;
      inp1  <= 8'hFF;
      sys_q <= 7'h7F;
    end else begin
      inp0  <= ~{left1, right1, up1, down1, 1'b0, trig2_1, trig1_1, 1'b0};
      inp1  <= ~{left2, right2, up2, down2, 1'b0, trig2_2, trig1_2, 1'b0};
      sys_q <= ~{2'b00, start2, start1, 3'b000};
    end
  end

  assign inp2 = {sys_q, coin_n};

  // coin_n and coin_busy are updated with the state so they line up with it exactly.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      coin_n    <= 1'b1;
      coin_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (coin_rise) begin
          state     <= PULSE;
          cnt       <= 4'd0;
          coin_n    <= 1'b0;
          coin_busy <= 1'b1;
        end
        PULSE: if (vb_rise) begin
          if (cnt + 4'd1 == COIN_TGT) begin
            state  <= GAP;
            cnt    <= 4'd0;
            coin_n <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: if (vb_rise) begin
          if (cnt + 4'd1 == GAP_TGT) begin
            state <= REARM;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        REARM: if (!raw_coin) begin
          state     <= IDLE;
          cnt       <= 4'd0;
          coin_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cnt       <= 4'd0;
          coin_n    <= 1'b1;
          coin_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys1_input_ctrl.sv
// Randomized and directed bench for sys1_input_ctrl against a behavioural model.
module tb_sys1_input_ctrl;

  localparam int COIN_FRAMES = 3;
  localparam int GAP_FRAMES  = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joy1, joy2;
  logic        cabinet, vblank;
  logic [7:0]  inp0, inp1, inp2;
  logic        coin_busy;

  always #5 clk_sys = ~clk_sys;

  sys1_input_ctrl #(.COIN_FRAMES(COIN_FRAMES), .GAP_FRAMES(GAP_FRAMES)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joy1(joy1), .joy2(joy2), .cabinet(cabinet), .vblank(vblank),
    .inp0(inp0), .inp1(inp1), .inp2(inp2), .coin_busy(coin_busy)
  );

  int tests = 0;
  int fails = 0;

  // Model state: pressed-key table by logical key, coin phase and frames seen in it.
  bit         keys [18];
  bit         tog_prev, raw_prev, vb_prev;
  int         phase;    // 0 idle, 1 coin pulse, 2 gap, 3 wait for release
  int         frames;
  logic [7:0] e0, e1, e2;
  logic       ebusy;
  int         pulses = 0;
  logic       last_coin = 1'b1;

  logic [7:0] codes [20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06,
                             8'h16, 8'h1E, 8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34,
                             8'h1C, 8'h1B, 8'h00, 8'h00};

  function automatic int key_index(logic ext, logic [7:0] code);
    case (code)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: ;
    endcase
    if (ext) return -1;
    case (code)
      8'h29: return 4;   8'h14: return 5;   8'h05: return 6;   8'h06: return 7;
      8'h16: return 8;   8'h1E: return 9;   8'h2E: return 10;  8'h36: return 11;
      8'h2D: return 12;  8'h2B: return 13;  8'h23: return 14;  8'h34: return 15;
      8'h1C: return 16;  8'h1B: return 17;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at each rising edge with the inputs the DUT is sampling.
  task automatic model_edge();
    bit u2, d2, l2, r2, a2, b2, u1, d1, l1, r1, a1, b1, s1, s2, raw, vrise;
    int idx;
    u2 = keys[12] | joy2[3];  d2 = keys[13] | joy2[2];
    l2 = keys[14] | joy2[1];  r2 = keys[15] | joy2[0];
    a2 = keys[16] | joy2[4];  b2 = keys[17] | joy2[5];
    u1 = keys[0] | joy1[3] | (!cabinet && u2);
    d1 = keys[1] | joy1[2] | (!cabinet && d2);
    l1 = keys[2] | joy1[1] | (!cabinet && l2);
    r1 = keys[3] | joy1[0] | (!cabinet && r2);
    a1 = keys[4] | joy1[4] | (!cabinet && a2);
    b1 = keys[5] | joy1[5] | (!cabinet && b2);
    s1 = keys[6] | keys[8] | joy1[6] | joy2[6];
    s2 = keys[7] | keys[9] | joy1[7] | joy2[7];
    raw = keys[6] | keys[7] | keys[10] | keys[11] | joy1[8] | joy2[8];
    vrise = vblank && !vb_prev;
    if (!reset_n) begin
      e0 = 8'hFF; e1 = 8'hFF; e2 = 8'hFF; ebusy = 1'b0;
      phase = 0; frames = 0;
      foreach (keys[i]) keys[i] = 1'b0;
    end else begin
      e0 = 8'hFF;
      if (l1) e0[7] = 1'b0;
      if (r1) e0[6] = 1'b0;
      if (u1) e0[5] = 1'b0;
      if (d1) e0[4] = 1'b0;
      if (b1) e0[2] = 1'b0;
      if (a1) e0[1] = 1'b0;
      e1 = 8'hFF;
      if (l2) e1[7] = 1'b0;
      if (r2) e1[6] = 1'b0;
      if (u2) e1[5] = 1'b0;
      if (d2) e1[4] = 1'b0;
      if (b2) e1[2] = 1'b0;
      if (a2) e1[1] = 1'b0;
      e2 = 8'hFF;
      if (s2) e2[5] = 1'b0;
      if (s1) e2[4] = 1'b0;
      if (phase == 0) begin
        if (raw && !raw_prev) begin phase = 1; frames = 0; end
      end else if (phase == 1 || phase == 2) begin
        if (vrise) begin
          frames++;
          if (frames == ((phase == 1) ? COIN_FRAMES : GAP_FRAMES)) begin
            phase++; frames = 0;
          end
        end
      end else if (!raw) begin
        phase = 0;
      end
      e2[0] = (phase != 1);
      ebusy = (phase != 0);
      if (ps2_key[10] != tog_prev) begin
        idx = key_index(ps2_key[8], ps2_key[7:0]);
        if (idx >= 0) keys[idx] = ps2_key[9];
      end
    end
    tog_prev = ps2_key[10];
    raw_prev = raw;
    vb_prev  = vblank;
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_edge();
    #1;
    check("inp0", inp0, e0);
    check("inp1", inp1, e1);
    check("inp2", inp2, e2);
    check("coin_busy", {7'd0, coin_busy}, {7'd0, ebusy});
    if (last_coin && !inp2[0]) pulses++;
    last_coin = inp2[0];
  endtask

  task automatic frame();
    vblank = 1'b1; step();
    vblank = 1'b0; step(); step(); step();
  endtask

  task automatic do_reset();
    joy1 = '0; joy2 = '0; vblank = 1'b0;
    reset_n = 1'b0; step(); step();
    reset_n = 1'b1;
  endtask

  task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  initial begin
    int p0, pf, gf;
    reset_n = 1'b0; ps2_key = '0; joy1 = '0; joy2 = '0;
    cabinet = 1'b1; vblank = 1'b0;
    step(); step();
    check("reset_inp0", inp0, 8'hFF);
    check("reset_inp2", inp2, 8'hFF);
    check("reset_busy", {7'd0, coin_busy}, 8'd0);
    reset_n = 1'b1;

    // Extended up key: two-cycle latency, then release.
    key(1'b1, 1'b1, 8'h75); step();
    check("key_lat1", inp0, 8'hFF);
    step();
    check("key_up", inp0, 8'hDF);
    key(1'b0, 1'b1, 8'h75); step(); step();
    check("key_up_rel", inp0, 8'hFF);

    // Upright cabinet mirrors P2 onto P1.
    cabinet = 1'b0; joy2[4] = 1'b1; step();
    check("upright_inp0", inp0, 8'hFD);
    check("upright_inp1", inp1, 8'hFD);
    cabinet = 1'b1; step();
    check("cocktail_inp0", inp0, 8'hFF);
    check("cocktail_inp1", inp1, 8'hFD);
    joy2 = '0; step();

    // One-cycle coin: pulse lasts three frames, busy three more.
    do_reset();
    joy1[8] = 1'b1; step(); joy1[8] = 1'b0;
    pf = 0; gf = 0;
    for (int f = 0; f < 8; f++) begin
      if (!inp2[0]) pf++;
      else if (coin_busy) gf++;
      frame();
    end
    check("pulse_frames", 8'(pf), 8'(COIN_FRAMES));
    check("gap_frames", 8'(gf), 8'(GAP_FRAMES));
    check("busy_done", {7'd0, coin_busy}, 8'd0);

    // Held coin gives a single pulse and waits for release.
    p0 = pulses;
    joy1[8] = 1'b1;
    for (int f = 0; f < 20; f++) frame();
    check("held_pulses", 8'(pulses - p0), 8'd1);
    check("held_busy", {7'd0, coin_busy}, 8'd1);
    joy1[8] = 1'b0; step();
    check("release_idle", {7'd0, coin_busy}, 8'd0);

    // Edge during the gap is dropped; a later edge is accepted.
    p0 = pulses;
    joy1[8] = 1'b1; step(); joy1[8] = 1'b0; step();
    for (int f = 0; f < 4; f++) frame();
    check("in_gap_coin", {7'd0, inp2[0]}, 8'd1);
    check("in_gap_busy", {7'd0, coin_busy}, 8'd1);
    joy1[8] = 1'b1; step(); joy1[8] = 1'b0; step();
    check("gap_edge_ignored", {7'd0, inp2[0]}, 8'd1);
    for (int f = 0; f < 6; f++) frame();
    check("gap_pulses", 8'(pulses - p0), 8'd1);
    joy1[8] = 1'b1; step(); joy1[8] = 1'b0;
    check("new_pulse", {7'd0, inp2[0]}, 8'd0);
    for (int f = 0; f < 8; f++) frame();

    // Reset mid-pulse with coin held.
    do_reset();
    joy1[8] = 1'b1; step(); frame();
    check("mid_pulse", {7'd0, inp2[0]}, 8'd0);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    check("rst_pulse_inp2", inp2, 8'hFF);
    p0 = pulses;
    for (int f = 0; f < 5; f++) frame();
    check("rst_no_pulse", 8'(pulses - p0), 8'd0);
    joy1[8] = 1'b0; step(); joy1[8] = 1'b1; step();
    check("rst_repress", {7'd0, inp2[0]}, 8'd0);
    joy1[8] = 1'b0;
    for (int f = 0; f < 8; f++) frame();

    // Randomized traffic checked every cycle by the model.
    codes[18] = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 3) == 0) begin
        codes[19] = 8'($urandom);
        key(1'($urandom), 1'($urandom), codes[$urandom_range(0, 19)]);
      end
      if ($urandom_range(0, 2) == 0) begin
        joy1[7:0] = 8'($urandom) & 8'($urandom);
        joy2[7:0] = 8'($urandom) & 8'($urandom);
        joy1[15:9] = 7'($urandom);
        joy2[15:9] = 7'($urandom);
      end
      if ($urandom_range(0, 39) == 0) joy1[8] = ~joy1[8];
      if ($urandom_range(0, 59) == 0) joy2[8] = ~joy2[8];
      if ($urandom_range(0, 2) == 0) vblank = ~vblank;
      if ($urandom_range(0, 49) == 0) cabinet = ~cabinet;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
